// File: rtl/p4_mem_stage.sv
// p4_mem_stage: MEM-stage controller; word load/store over a ready/valid
// port, pipeline stall generation and MEM/WB output registers.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   ex_type/result/     EX/MEM bundle (result is the byte address
//   store/rd            for loads and stores)
//   stall               combinational freeze to EX/MEM and earlier
//   mem_req/we/addr/    registered data-memory request
//   wdata
//   mem_ready/rdata     memory completion and load data
//   wb_type/rd/data/en  registered MEM/WB bundle
//   misalign_err        one-cycle pulse, misaligned load/store
//   bus_err             one-cycle pulse, access timed out
module p4_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  ex_type,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  wb_type,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT - 1);

  localparam logic [2:0] T_RALU  = 3'd0;
  localparam logic [2:0] T_IALU  = 3'd1;
  localparam logic [2:0] T_LOAD  = 3'd2;
  localparam logic [2:0] T_STORE = 3'd3;
  localparam logic [2:0] T_JUMP  = 3'd5;
  localparam logic [2:0] T_BUBB  = 3'd7;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_d;

  logic [CW-1:0] cnt, cnt_d;
  logic          req_d, we_d;
  logic [31:0]   addr_d, wdata_d;
  logic [2:0]    wb_type_d;
  logic [4:0]    wb_rd_d;
  logic [31:0]   wb_data_d;
  logic          wb_en_d;
  logic          mis_d, bus_d;

  logic is_ls, aligned;
  logic mem_op, mis_op;
  logic last, rd_nz, alu_wr;

  assign is_ls   = (ex_type == T_LOAD) ||
                   (ex_type == T_STORE);
  assign aligned = (ex_result[1:0] == 2'b00);
  assign mem_op  = is_ls && aligned;
  assign mis_op  = is_ls && !aligned;
  assign last    = (cnt == LAST);
  assign rd_nz   = (ex_rd != 5'd0);
  assign alu_wr  = (ex_type == T_RALU) ||
                   (ex_type == T_IALU) ||
                   (ex_type == T_JUMP);

  // Stall drops in the final ACCESS cycle so EX/MEM
  // advances on the edge that MEM/WB captures.
  assign stall =
    ((state == IDLE) && mem_op) ||
    ((state == ACCESS) && !mem_ready && !last);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    req_d     = mem_req;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    wb_type_d = T_BUBB;
    wb_rd_d   = 5'd0;
    wb_data_d = 32'd0;
    wb_en_d   = 1'b0;
    mis_d     = 1'b0;
    bus_d     = 1'b0;
    case (state)
      IDLE: begin
        unique case (1'b1)
          mem_op: begin
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = (ex_type == T_STORE);
            addr_d  = {ex_result[31:2], 2'b00};
            wdata_d = ex_store;
          end
          mis_op: begin
            mis_d = 1'b1;
          end
          default: begin
            wb_type_d = ex_type;
            wb_rd_d   = ex_rd;
            wb_data_d = ex_result;
            wb_en_d   = alu_wr && rd_nz;
          end
        endcase
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          wb_type_d = ex_type;
          wb_rd_d   = ex_rd;
          if (!mem_we) begin
            wb_data_d = mem_rdata;
            wb_en_d   = rd_nz;
          end
        end else if (last) begin
          state_d = IDLE;
          req_d   = 1'b0;
          bus_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      wb_type      <= T_BUBB;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      mem_req      <= req_d;
      mem_we       <= we_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      wb_type      <= wb_type_d;
      wb_rd        <= wb_rd_d;
      wb_data      <= wb_data_d;
      wb_en        <= wb_en_d;
      misalign_err <= mis_d;
      bus_err      <= bus_d;
    end
  end

endmodule

// File: tb/tb_p4_mem_stage.sv
// tb_p4_mem_stage: directed vector table for single-cycle ops plus
// hand-written load/store/timeout/reset sequences (TIMEOUT = 4).
module tb_p4_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  ex_type;
  logic [31:0] ex_result;
  logic [31:0] ex_store;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  wb_type;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        misalign_err;
  logic        bus_err;

  p4_mem_stage #(.TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_type      (ex_type),
    .ex_result    (ex_result),
    .ex_store     (ex_store),
    .ex_rd        (ex_rd),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .wb_type      (wb_type),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_en        (wb_en),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [2:0]  et;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        een;
    logic        emis;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] t,
                       input logic [31:0] r,
                       input logic [31:0] s,
                       input logic [4:0] d);
    ex_type   = t;
    ex_result = r;
    ex_store  = s;
    ex_rd     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int stalls;
    int reqs;

    v[0] = '{3'd0, 32'h1234,     5'd5,
             3'd0, 5'd5,  32'h1234,     1'b1, 1'b0};
    v[1] = '{3'd1, 32'h77,       5'd0,
             3'd1, 5'd0,  32'h77,       1'b0, 1'b0};
    v[2] = '{3'd4, 32'h400,      5'd7,
             3'd4, 5'd7,  32'h400,      1'b0, 1'b0};
    v[3] = '{3'd5, 32'h80,       5'd31,
             3'd5, 5'd31, 32'h80,       1'b1, 1'b0};
    v[4] = '{3'd6, 32'h9,        5'd2,
             3'd6, 5'd2,  32'h9,        1'b0, 1'b0};
    v[5] = '{3'd7, 32'h3,        5'd4,
             3'd7, 5'd4,  32'h3,        1'b0, 1'b0};
    v[6] = '{3'd2, 32'h102,      5'd3,
             3'd7, 5'd0,  32'h0,        1'b0, 1'b1};
    v[7] = '{3'd3, 32'h41,       5'd8,
             3'd7, 5'd0,  32'h0,        1'b0, 1'b1};
    v[8] = '{3'd0, 32'hFFFFFFFF, 5'd1,
             3'd0, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b0};

    drive(3'd7, 32'd0, 32'd0, 5'd0);
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    reset     = 1'b1;
    #3;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wbt",   32'(wb_type), 32'd7);
    chk("rst_wbrd",  32'(wb_rd), 32'd0);
    chk("rst_wbd",   wb_data, 32'd0);
    chk("rst_wben",  32'(wb_en), 32'd0);
    chk("rst_mis",   32'(misalign_err), 32'd0);
    chk("rst_bus",   32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    #4 reset = 1'b0;
    tick();

    // mem_ready held high here: must be ignored outside ACCESS.
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 9; i++) begin
      drive(v[i].t, v[i].res, 32'hCAFE0000, v[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
      tick();
      chk($sformatf("v%0d_wbt", i),
          32'(wb_type), 32'(v[i].et));
      chk($sformatf("v%0d_wbrd", i),
          32'(wb_rd), 32'(v[i].erd));
      chk($sformatf("v%0d_wbd", i), wb_data, v[i].ed);
      chk($sformatf("v%0d_wben", i),
          32'(wb_en), 32'(v[i].een));
      chk($sformatf("v%0d_mis", i),
          32'(misalign_err), 32'(v[i].emis));
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d_bus", i), 32'(bus_err), 32'd0);
    end
    mem_ready = 1'b0;
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    tick();

    // Load, ready in the 3rd ACCESS cycle.
    drive(3'd2, 32'h100, 32'h11111111, 5'd3);
    #1;
    stalls = stall ? 1 : 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      #1;
      chk($sformatf("ld_req%0d", c), 32'(mem_req), 32'd1);
      chk($sformatf("ld_addr%0d", c), mem_addr, 32'h100);
      chk($sformatf("ld_we%0d", c), 32'(mem_we), 32'd0);
      chk($sformatf("ld_wben%0d", c), 32'(wb_en), 32'd0);
      chk($sformatf("ld_wbt%0d", c), 32'(wb_type), 32'd7);
      if (stall) stalls++;
    end
    chk("ld_stalls", 32'(stalls), 32'd3);
    tick();
    mem_ready = 1'b0;
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    chk("ld_req_off", 32'(mem_req), 32'd0);
    chk("ld_wbd",  wb_data, 32'hDEADBEEF);
    chk("ld_wben", 32'(wb_en), 32'd1);
    chk("ld_wbrd", 32'(wb_rd), 32'd3);
    chk("ld_wbt",  32'(wb_type), 32'd2);
    tick();

    // Store, ready on the first ACCESS cycle.
    drive(3'd3, 32'h40, 32'hA5A5A5A5, 5'd0);
    #1;
    stalls = stall ? 1 : 0;
    tick();
    mem_ready = 1'b1;
    #1;
    if (stall) stalls++;
    chk("st_req",   32'(mem_req), 32'd1);
    chk("st_we",    32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("st_addr",  mem_addr, 32'h40);
    tick();
    mem_ready = 1'b0;
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    #1;
    if (stall) stalls++;
    chk("st_req_off", 32'(mem_req), 32'd0);
    chk("st_wben", 32'(wb_en), 32'd0);
    chk("st_wbd",  wb_data, 32'd0);
    chk("st_wbt",  32'(wb_type), 32'd3);
    chk("st_stalls", 32'(stalls), 32'd1);
    tick();

    // Ready on the last allowed cycle beats the timeout.
    drive(3'd2, 32'h80, 32'd0, 5'd12);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
      end
      #1;
      chk($sformatf("rw_stall%0d", c),
          32'(stall), (c < 4) ? 32'd1 : 32'd0);
    end
    tick();
    mem_ready = 1'b0;
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    chk("rw_bus",  32'(bus_err), 32'd0);
    chk("rw_wbd",  wb_data, 32'h0BADF00D);
    chk("rw_wben", 32'(wb_en), 32'd1);
    chk("rw_wbrd", 32'(wb_rd), 32'd12);
    tick();

    // Timeout with mem_ready held low.
    drive(3'd2, 32'h200, 32'd0, 5'd4);
    reqs = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      if (mem_req) reqs++;
      chk($sformatf("to_bus%0d", c), 32'(bus_err), 32'd0);
      chk($sformatf("to_stall%0d", c),
          32'(stall), (c < 4) ? 32'd1 : 32'd0);
    end
    tick();
    drive(3'd0, 32'h55, 32'd0, 5'd9);
    #1;
    if (mem_req) reqs++;
    chk("to_reqs", 32'(reqs), 32'd4);
    chk("to_bus",  32'(bus_err), 32'd1);
    chk("to_wbt",  32'(wb_type), 32'd7);
    chk("to_wben", 32'(wb_en), 32'd0);
    chk("to_wbrd", 32'(wb_rd), 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    tick();
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    chk("to_bus_off", 32'(bus_err), 32'd0);
    chk("to_alu_en",  32'(wb_en), 32'd1);
    chk("to_alu_rd",  32'(wb_rd), 32'd9);
    chk("to_alu_d",   wb_data, 32'h55);
    tick();

    // Reset while in ACCESS.
    drive(3'd2, 32'h300, 32'd0, 5'd6);
    tick();
    #1;
    chk("mr_req_on", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_req",  32'(mem_req), 32'd0);
    chk("mr_wbt",  32'(wb_type), 32'd7);
    chk("mr_wben", 32'(wb_en), 32'd0);
    drive(3'd7, 32'd0, 32'd0, 5'd0);
    #1 reset = 1'b0;
    tick();
    chk("mr_req2",  32'(mem_req), 32'd0);
    chk("mr_wben2", 32'(wb_en), 32'd0);
    chk("mr_wbt2",  32'(wb_type), 32'd7);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
